registro_serializador: RTL and testbench
========================================

// Module: registro_serializador
// PURPOSE
//  Parallel-in/serial-out register: captures an N-bit word through a valid/ready
//  handshake and shifts it out one bit per enabled clock, with valid/last framing.
//  It is the read-out counterpart of the parallel-load register bank. It feeds
//  serial links and bit-serial datapaths from a parallel word.
// PARAMETERS
//  N          8   word width in bits; legal range N >= 2
//  MSB_FIRST  1   1: send d[N-1] first; 0: send d[0] first
// PORTS
//  clk        in   1   system clock; all state changes on the rising edge
//  rst        in   1   asynchronous reset, active-low (rst=0 resets immediately)
//  in_valid   in   1   in_data holds a word to load
//  in_ready   out  1   block can accept a word this cycle (combinational from state)
//  in_data    in   N   parallel word
//  ser_en     in   1   shift enable / downstream ready; 0 stalls the shifter
//  ser_out    out  1   current serial bit (registered)
//  ser_valid  out  1   ser_out carries a valid bit (registered)
//  ser_last   out  1   ser_out is the final bit of the word (registered)
//  busy       out  1   high in SHIFT state
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE; shift register=0; cnt=0.
//    ser_out=0, ser_valid=0, ser_last=0, busy=0. in_ready=1 after reset.
//    Reset mid-word aborts the word; no partial output follows release.
//  - State machine has two states:
//    IDLE : in_ready=1. A load occurs when in_valid=1. The word is captured at
//           that edge. Next cycle: state=SHIFT, cnt=0, first bit on ser_out.
//    SHIFT: ser_valid=1, busy=1. ser_out is the bit at position cnt, in
//           MSB_FIRST order. ser_last=1 exactly when cnt==N-1.
//           With ser_en=1: the bit is consumed at the edge; shift; cnt++.
//           With ser_en=0: everything holds (state, cnt, ser_* unchanged).
//  - End of word: the last bit is consumed when cnt==N-1 and ser_en=1.
//    in_ready=1 in that same cycle. This is the back-to-back window.
//    If in_valid=1 there: the new word loads at that edge and stays in SHIFT,
//    cnt=0, with no idle gap. Otherwise go to IDLE; ser_valid=0 next cycle.
//  - in_ready = (state==IDLE) | (state==SHIFT & cnt==N-1 & ser_en).
//    The block never loads when in_ready=0. in_data is ignored outside a load.
//  - Latency: 1 cycle from the load edge to the first bit.
//    A word occupies exactly N enabled cycles.
//  - cnt width is $clog2(N). Compare cnt with N-1 for termination; never wrap past N-1.
//  - in_valid and ser_en may both be 0 in SHIFT: hold, no load.
// TESTING
//  1. Reset: hold rst=0 with random inputs -> ser_valid=ser_last=busy=0,
//     in_ready=1. Assert rst mid-clock -> outputs clear before the next edge.
//  2. N=8, MSB_FIRST=1, ser_en=1: load 0xA5 -> ser_out 1,0,1,0,0,1,0,1
//     on 8 consecutive cycles. ser_last only on the 8th; IDLE the cycle after.
//  3. MSB_FIRST=0: load 0x01 -> ser_out 1,0,0,0,0,0,0,0.
//     in_ready=0 during cycles 1..7 even with in_valid=1.
//  4. Back-to-back: hold in_valid=1 with 0xFF then 0x00 -> 16 contiguous
//     ser_valid cycles (8 ones then 8 zeros). ser_last on the 8th and 16th.
//  5. Stall: load 0xC3; drop ser_en for 3 cycles after bit 2 -> ser_out/cnt frozen.
//     Full word still 1,1,0,0,0,0,1,1. Stall on the last bit -> in_ready=0 until ser_en=1.
//  6. Reset mid-word: rst=0 after bit 4 of 0x5A, release, no in_valid
//     -> ser_valid stays 0; next load 0x81 serializes correctly.

Source files
------------

// File: rtl/registro_serializador_if.sv
// Handshake and serial-side signal bundle for registro_serializador.
interface registro_serializador_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         ser_en;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  modport master (
    output in_valid, in_data, ser_en,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data, ser_en,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/registro_serializador.sv
// Parallel-in/serial-out register: loads an N-bit word on a valid/ready
// handshake and shifts it out one bit per enabled cycle with valid/last framing.
module registro_serializador #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  registro_serializador_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(N - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state, state_nx;
  logic [N-1:0]   sreg, sreg_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           last, last_nx;
  logic [N-1:0]   shifted;
  logic           at_end;
  logic           ready;

  // The outgoing bit always sits at the leading end of the shift register,
  // so ser_out is a direct flop output; zero fill leaves it 0 once a word ends.
  assign shifted = MSB_FIRST ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
  assign at_end  = (cnt == CNT_LAST);
  assign ready   = (state == IDLE) || ((state == SHIFT) && at_end && bus.ser_en);

  assign bus.in_ready  = ready;
  assign bus.ser_out   = MSB_FIRST ? sreg[N-1] : sreg[0];
  assign bus.ser_valid = (state == SHIFT);
  assign bus.busy      = (state == SHIFT);
  assign bus.ser_last  = last;

  // State, shift register, bit counter and last flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
    end
  end

  // Next-state: load on handshake, shift on enable, hold on stall.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx = SHIFT;
          sreg_nx  = bus.in_data;
          cnt_nx   = '0;
          last_nx  = 1'b0;
        end
      end
      SHIFT: begin
        if (bus.ser_en) begin
          if (at_end) begin
            cnt_nx  = '0;
            last_nx = 1'b0;
            if (bus.in_valid) begin
              sreg_nx = bus.in_data;
            end else begin
              state_nx = IDLE;
              sreg_nx  = shifted;
            end
          end else begin
            sreg_nx = shifted;
            cnt_nx  = cnt + CW'(1);
            last_nx = (cnt == CNT_PREV);
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_registro_serializador.sv
// Self-checking bench for registro_serializador: MSB-first and LSB-first
// instances share stimulus and are compared against a word/index model.
module tb_registro_serializador;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_en;

  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, an active flag, the captured word and the
  // index of the bit currently presented (0 = first bit sent).
  logic       act  [2];
  int         idx  [2];
  logic [7:0] word [2];

  registro_serializador_if #(.N(N)) bus_m ();
  registro_serializador_if #(.N(N)) bus_l ();

  assign bus_m.in_valid = in_valid;
  assign bus_m.in_data  = in_data;
  assign bus_m.ser_en   = ser_en;
  assign bus_l.in_valid = in_valid;
  assign bus_l.in_data  = in_data;
  assign bus_l.ser_en   = ser_en;

  registro_serializador #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  registro_serializador #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k]  = 1'b0;
      idx[k]  = 0;
      word[k] = '0;
    end
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step(input logic v, input logic [7:0] d, input logic en);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        act[k] = 1'b0;
        idx[k] = 0;
      end else if (act[k]) begin
        if (en) begin
          if (idx[k] == N - 1) begin
            idx[k] = 0;
            if (v) word[k] = d;
            else   act[k]  = 1'b0;
          end else begin
            idx[k] = idx[k] + 1;
          end
        end
      end else if (v) begin
        act[k]  = 1'b1;
        word[k] = d;
        idx[k]  = 0;
      end
    end
  endtask

  function automatic logic exp_bit(input int k);
    if (!act[k]) return 1'b0;
    return (k == 0) ? word[k][N - 1 - idx[k]] : word[k][idx[k]];
  endfunction

  task automatic check_all(input logic en, input int want_m, input int want_l);
    logic exp_rdy;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = !act[k] || ((idx[k] == N - 1) && en);
      if (k == 0) begin
        chk("m.in_ready",  bus_m.in_ready,  exp_rdy);
        chk("m.ser_out",   bus_m.ser_out,   exp_bit(0));
        chk("m.ser_valid", bus_m.ser_valid, act[0]);
        chk("m.ser_last",  bus_m.ser_last,  act[0] && (idx[0] == N - 1));
        chk("m.busy",      bus_m.busy,      act[0]);
      end else begin
        chk("l.in_ready",  bus_l.in_ready,  exp_rdy);
        chk("l.ser_out",   bus_l.ser_out,   exp_bit(1));
        chk("l.ser_valid", bus_l.ser_valid, act[1]);
        chk("l.ser_last",  bus_l.ser_last,  act[1] && (idx[1] == N - 1));
        chk("l.busy",      bus_l.busy,      act[1]);
      end
    end
    if (want_m >= 0) chk("m.pattern", bus_m.ser_out, want_m[0]);
    if (want_l >= 0) chk("l.pattern", bus_l.ser_out, want_l[0]);
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+4, step model at edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic en,
                       input int want_m, input int want_l);
    in_valid = v;
    in_data  = d;
    ser_en   = en;
    if (!rst) model_reset();
    #3;
    check_all(en, want_m, want_l);
    @(posedge clk);
    model_step(v, d, en);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ser_en   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++)
      cycle(1'($urandom), 8'($urandom), 1'($urandom), -1, -1);
    rst = 1'b1;

    // 0xA5 streamed with ser_en held high.
    pat = 8'hA5;
    cycle(1'b1, pat, 1'b1, -1, -1);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'($urandom), 1'b1, int'(pat[7 - i]), int'(pat[i]));
    cycle(1'b0, 8'h00, 1'b1, 0, 0);

    // 0x01 with in_valid kept high while the word is in flight.
    pat = 8'h01;
    cycle(1'b1, pat, 1'b1, -1, -1);
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 8'($urandom), 1'b1, int'(pat[7 - i]), int'(pat[i]));
    cycle(1'b0, 8'($urandom), 1'b1, int'(pat[0]), int'(pat[7]));
    cycle(1'b0, 8'h00, 1'b1, -1, -1);

    // Back-to-back 0xFF then 0x00.
    cycle(1'b1, 8'hFF, 1'b1, -1, -1);
    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i == 7) ? 8'h00 : 8'hFF, 1'b1, 1, 1);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'($urandom), 1'b1, 0, 0);
    cycle(1'b0, 8'h00, 1'b1, -1, -1);

    // 0xC3 with stalls mid-word and on the last bit.
    pat = 8'hC3;
    cycle(1'b1, pat, 1'b1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        for (int s = 0; s < 3; s++)
          cycle(1'b1, 8'($urandom), 1'b0, int'(pat[7 - i]), int'(pat[i]));
      end
      if (i == 7) begin
        for (int s = 0; s < 2; s++)
          cycle(1'b1, 8'($urandom), 1'b0, int'(pat[7 - i]), int'(pat[i]));
      end
      cycle(1'b0, 8'($urandom), 1'b1, int'(pat[7 - i]), int'(pat[i]));
    end
    cycle(1'b0, 8'h00, 1'b1, -1, -1);

    // Reset mid-word of 0x5A, then 0x81 serializes cleanly.
    cycle(1'b1, 8'h5A, 1'b1, -1, -1);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 8'($urandom), 1'b1, -1, -1);
    rst = 1'b0;
    cycle(1'b0, 8'($urandom), 1'b1, 0, 0);
    cycle(1'b1, 8'($urandom), 1'b1, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 8'($urandom), 1'($urandom), 0, 0);
    pat = 8'h81;
    cycle(1'b1, pat, 1'b1, -1, -1);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'($urandom), 1'b1, int'(pat[7 - i]), int'(pat[i]));

    // Randomized traffic with stalls, back-to-back loads and rare resets.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      cycle(($urandom_range(0, 2) == 0), 8'($urandom),
            ($urandom_range(0, 3) != 0), -1, -1);
    end
    rst = 1'b1;
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 8'($urandom), 1'b1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
